// File: rtl/ldac_window_sched.sv
// LDAC window scheduler.
// Two requesters propose a [left, right] pulse window. One accepted window at a time is held in a
// shadow register and committed to the live bounds only at a phase wrap, so the LDAC pulse
// generator never sees a bound change in the middle of a period.
module ldac_window_sched #(
  parameter int unsigned BIT = 8
) (
  input  logic           clk_in,
  input  logic           rst_n,
  input  logic           req_a,
  input  logic [BIT-1:0] left_a,
  input  logic [BIT-1:0] right_a,
  input  logic           req_b,
  input  logic [BIT-1:0] left_b,
  input  logic [BIT-1:0] right_b,
  output logic           gnt_a,
  output logic           gnt_b,
  output logic           err,
  output logic           busy,
  output logic [BIT-1:0] left_out,
  output logic [BIT-1:0] right_out,
  output logic           wrap
);

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } state_e;

  state_e         state_q, state_d;
  logic [BIT-1:0] phase_q;
  // High when B wins a tie, i.e. A was granted most recently.
  logic           prio_b_q;
  logic [BIT-1:0] shadow_left_q, shadow_right_q;
  logic [BIT-1:0] left_out_q, right_out_q;

  logic           any_req;
  logic           sel_b;
  logic [BIT-1:0] sel_left, sel_right;
  logic [BIT:0]   sel_left_inc;
  logic           win_empty;
  logic           wrap_now;
  logic           grant;
  logic           latch;
  logic           commit;

  // Round-robin arbitration and emptiness test of the selected window.
  always_comb begin
    any_req      = req_a | req_b;
    sel_b        = req_b & (~req_a | prio_b_q);
    sel_left     = sel_b ? left_b : left_a;
    sel_right    = sel_b ? right_b : right_a;
    // One extra bit so left = 2^BIT-1 cannot overflow the +1.
    sel_left_inc = {1'b0, sel_left} + {{BIT{1'b0}}, 1'b1};
    win_empty    = ({1'b0, sel_right} <= sel_left_inc);
    wrap_now     = (phase_q == {BIT{1'b1}});
  end

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    latch   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant = 1'b1;
          // Empty windows are still granted (so the requester can drop) but never latched.
          if (!win_empty) begin
            latch   = 1'b1;
            state_d = StPend;
          end
        end
      end
      StPend: begin
        // A grant taken on a wrap cycle enters PEND afterwards, so it waits a full period.
        if (wrap_now) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; pulses are masked during reset so they read 0 immediately.
  always_comb begin
    gnt_a     = grant & ~sel_b & rst_n;
    gnt_b     = grant & sel_b & rst_n;
    err       = grant & win_empty & rst_n;
    busy      = (state_q == StPend);
    left_out  = left_out_q;
    right_out = right_out_q;
    wrap      = wrap_now;
  end

  // Free-running phase counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + {{(BIT-1){1'b0}}, 1'b1};
    end
  end

  // FSM state register and round-robin pointer.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        prio_b_q <= ~sel_b;
      end
    end
  end

  // Shadow bounds captured on an accepted grant.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shadow_left_q  <= '0;
      shadow_right_q <= '0;
    end else if (latch) begin
      shadow_left_q  <= sel_left;
      shadow_right_q <= sel_right;
    end
  end

  // Live bounds, updated only at a wrap commit so they are valid from phase 0.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      left_out_q  <= '0;
      right_out_q <= '0;
    end else if (commit) begin
      left_out_q  <= shadow_left_q;
      right_out_q <= shadow_right_q;
    end
  end

endmodule

// File: tb/tb_ldac_window_sched.sv
// Scoreboard bench for ldac_window_sched: stimulus pushes expected grants and commits, a monitor
// pops and compares whenever a grant pulses or the live bounds change.
module tb_ldac_window_sched;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       req_a  = 1'b0;
  logic [7:0] left_a = '0;
  logic [7:0] right_a = '0;
  logic       req_b  = 1'b0;
  logic [7:0] left_b = '0;
  logic [7:0] right_b = '0;
  logic       gnt_a, gnt_b, err, busy, wrap;
  logic [7:0] left_out, right_out;

  ldac_window_sched #(.BIT(8)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .left_a    (left_a),
    .right_a   (right_a),
    .req_b     (req_b),
    .left_b    (left_b),
    .right_b   (right_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .err       (err),
    .busy      (busy),
    .left_out  (left_out),
    .right_out (right_out),
    .wrap      (wrap)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit is_commit;
    bit who_b;
    bit is_err;
    int ph;   // expected phase of a grant, -1 = any
    int l;
    int r;
    int cyc;  // expected cycle a commit becomes visible, -1 = any
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ph     = 0;
  int   cyc    = 0;

  // Reference phase and absolute cycle count.
  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else        ph <= (ph + 1) % 256;
  end
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: commits are processed before grants since both can appear at phase 0.
  initial begin : monitor
    int   pl, pr;
    exp_t e;
    pl = 0;
    pr = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n) begin
        pl = left_out;
        pr = right_out;
      end else begin
        if (left_out != pl || right_out != pr) begin
          if (q.size() == 0) begin
            check("unexpected_commit", 1, 0);
          end else begin
            e = q.pop_front();
            check("commit_kind", 1, e.is_commit);
            check("commit_left", left_out, e.l);
            check("commit_right", right_out, e.r);
            check("commit_phase", ph, 0);
            if (e.cyc >= 0) check("commit_cycle", cyc, e.cyc);
          end
          pl = left_out;
          pr = right_out;
        end
        if (gnt_a || gnt_b) begin
          if (q.size() == 0) begin
            check("unexpected_grant", 1, 0);
          end else begin
            e = q.pop_front();
            check("grant_kind", 0, e.is_commit);
            check("grant_onehot", gnt_a ^ gnt_b, 1);
            check("grant_who_b", gnt_b, e.who_b);
            check("grant_err", err, e.is_err);
            if (e.ph >= 0) check("grant_phase", ph, e.ph);
          end
        end else if (err) begin
          check("stray_err", 1, 0);
        end
      end
    end
  end

  // Called just after a rising edge. commit_ofs: -2 = no commit, -1 = any cycle.
  task automatic do_req(input bit who_b, input int l, input int r, input bit exp_err,
                        input int exp_ph, input int commit_ofs);
    exp_t e;
    bit   seen;
    e = '{is_commit: 0, who_b: who_b, is_err: exp_err, ph: exp_ph, l: l, r: r, cyc: -1};
    q.push_back(e);
    if (!exp_err && commit_ofs != -2) begin
      e.is_commit = 1;
      e.cyc = (commit_ofs >= 0) ? cyc + commit_ofs : -1;
      q.push_back(e);
    end
    if (who_b) begin
      req_b = 1; left_b = 8'(l); right_b = 8'(r);
    end else begin
      req_a = 1; left_a = 8'(l); right_a = 8'(r);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_in);
      seen = who_b ? gnt_b : gnt_a;
    end
    if (!seen) check("grant_timeout", 0, 1);
    @(posedge clk_in);
    #1;
    req_a = 0;
    req_b = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk_in);
      done = !busy;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 300 && ph != p; i++) begin
      @(posedge clk_in);
      #1;
    end
    if (ph != p) check("phase_timeout", ph, p);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   n;
    // Both requesters high during reset: nothing may come out.
    req_a = 1; left_a = 40; right_a = 50;
    req_b = 1; left_b = 60; right_b = 70;
    #12;
    check("rst_gnt_a", gnt_a, 0);
    check("rst_gnt_b", gnt_b, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_wrap", wrap, 0);

    // Round robin from reset: A, B, A, each grant at phase 0 right after the previous commit.
    e = '{is_commit: 0, who_b: 0, is_err: 0, ph: 0, l: 0, r: 0, cyc: -1};
    for (int k = 0; k < 3; k++) begin
      e.is_commit = 0; e.who_b = (k == 1); e.ph = 0;
      q.push_back(e);
      e.is_commit = 1; e.l = (k == 1) ? 60 : 40; e.r = (k == 1) ? 70 : 50;
      e.cyc = (k == 0) ? 256 : -1;
      q.push_back(e);
    end
    @(posedge clk_in);
    #1;
    rst_n = 1;
    cyc = 0;
    n = 0;
    for (int i = 0; i < 2000 && n < 3; i++) begin
      @(negedge clk_in);
      if (gnt_a || gnt_b) n++;
    end
    check("rr_grant_count", n, 3);
    @(posedge clk_in);
    #1;
    req_a = 0;
    req_b = 0;
    wait_idle();

    // Normal window granted at phase 5; a request dropped during PEND is ignored.
    @(posedge clk_in);
    #1;
    wait_phase(5);
    check("wrap_low", wrap, 0);
    do_req(0, 10, 20, 0, 5, 251);
    repeat (3) @(posedge clk_in);
    #1;
    check("busy_pend", busy, 1);
    req_b = 1; left_b = 1; right_b = 9;
    repeat (2) @(posedge clk_in);
    #1;
    req_b = 0;
    wait_idle();
    check("out_left_10", left_out, 10);
    check("out_right_20", right_out, 20);

    // Empty window 30..31: err with gnt_b, nothing latched.
    @(posedge clk_in);
    #1;
    do_req(1, 30, 31, 1, -1, -2);
    @(negedge clk_in);
    check("empty_busy", busy, 0);
    check("empty_left", left_out, 10);
    check("empty_right", right_out, 20);

    // Full-range window is accepted; 254..255 is empty.
    @(posedge clk_in);
    #1;
    do_req(0, 0, 255, 0, -1, -1);
    wait_idle();
    @(posedge clk_in);
    #1;
    do_req(0, 254, 255, 1, -1, -2);
    @(negedge clk_in);
    check("edge_busy", busy, 0);

    // Grant on the wrap cycle commits one full period later.
    @(posedge clk_in);
    #1;
    wait_phase(255);
    check("wrap_high", wrap, 1);
    do_req(0, 100, 200, 0, 255, 257);
    wait_idle();

    // Reset in the middle of PEND discards the pending window.
    @(posedge clk_in);
    #1;
    do_req(0, 5, 9, 0, -1, -2);
    repeat (20) @(posedge clk_in);
    #2;
    rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_left", left_out, 0);
    check("midrst_right", right_out, 0);
    @(posedge clk_in);
    #1;
    rst_n = 1;
    repeat (300) @(negedge clk_in);
    check("postrst_left", left_out, 0);
    check("postrst_right", right_out, 0);
    check("postrst_busy", busy, 0);
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldac_window_sched.md
LDAC_WINDOW_SCHED -- requirements
Module: ldac_window_sched

Interface
REQ-001 Parameter: BIT, default 8, width of the window bounds and the phase counter.
REQ-002 The clock and reset ports SHALL be:
- clk_in  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 The remaining ports SHALL be:
- req_a  in  1  requester A wants a window update.
- left_a  in  BIT  requester A lower bound.
- right_a  in  BIT  requester A upper bound.
- req_b  in  1  requester B wants a window update.
- left_b  in  BIT  requester B lower bound.
- right_b  in  BIT  requester B upper bound.
- gnt_a  out  1  one-cycle accept pulse to requester A.
- gnt_b  out  1  one-cycle accept pulse to requester B.
- err  out  1  one-cycle pulse: the accepted window was rejected as empty.
- busy  out  1  an accepted window is pending commit.
- left_out  out  BIT  active lower bound, drives the LDAC pulse generator.
- right_out  out  BIT  active upper bound, drives the LDAC pulse generator.
- wrap  out  1  high while phase == 2^BIT-1.

Function
REQ-004 The block SHALL hold a BIT-bit free-running phase counter that increments by 1 every cycle and wraps from 2^BIT-1 to 0.
REQ-005 The block SHALL implement a two-state FSM: IDLE and PEND.
REQ-006 In IDLE with at least one req_x high, the block SHALL grant exactly one requester, latch its left/right into the shadow registers, pulse its gnt_x for one cycle, and go to PEND the next cycle.
REQ-007 Arbitration SHALL be round-robin: when both requests are high, the requester not granted most recently wins; after reset, A has priority.
REQ-008 In PEND, no gnt_x SHALL be asserted; requesters SHALL hold req_x and their bounds until granted.
REQ-009 A window SHALL be empty when right <= left + 1, computed in BIT+1 bits with no overflow; an empty window SHALL be granted, SHALL pulse err in the same cycle as gnt_x, SHALL NOT be latched, and the FSM SHALL stay in IDLE.
REQ-010 In PEND, on the cycle phase == 2^BIT-1, left_out/right_out SHALL load the shadow values, registered so they are valid from the cycle phase == 0, and the FSM SHALL return to IDLE.
REQ-011 A grant issued on the cycle phase == 2^BIT-1 SHALL commit at the following wrap, not the current one.
REQ-012 left_out/right_out SHALL change only on a wrap commit, never mid-period.
REQ-013 busy SHALL be high exactly while the FSM is in PEND.
REQ-014 A new request SHALL be grantable on the cycle after the commit cycle (FSM back in IDLE).
REQ-015 A request that drops before being granted SHALL be ignored without error.

Reset
REQ-016 On rst_n low, asynchronously: phase=0, FSM=IDLE, left_out=0, right_out=0, shadow=0, gnt_a=gnt_b=err=0, busy=0, round-robin pointer=A.
REQ-017 With left_out=right_out=0, the driven LDAC output SHALL remain high (no load pulse).
REQ-018 Reset asserted while in PEND SHALL discard the pending window; no commit SHALL follow.
REQ-019 After rst_n deasserts, the first phase increment SHALL occur on the first rising clk_in edge.

Verification
REQ-020 req_a with left_a=10, right_a=20 at phase 5 -> gnt_a pulses at phase 5; busy high; left_out=10, right_out=20 first visible at phase 0 of the next period.
REQ-021 req_a and req_b both high from reset -> A is granted first, then B after A commits; with both still high, the grants alternate A, B, A.
REQ-022 req_b with left_b=30, right_b=31 -> gnt_b and err pulse together; busy stays 0; outputs unchanged.
REQ-023 Grant at phase 255 (BIT=8) -> no commit at that wrap; commit occurs 256 cycles later.
REQ-024 rst_n pulled low mid-PEND -> all outputs 0 immediately; after release, no commit occurs at the next wrap.
REQ-025 req_a with left_a=0, right_a=255 -> accepted and committed; a boundary of 255 with left_a=254 is flagged err.
